rv32e_mem_arbiter: RTL and testbench

- Shares one single-ported 32-bit memory between the CPU's instruction-fetch port and its load/store data port. This prepares the later collapse of the separate program and data buses into one memory.
- Each requester uses a req/ack handshake. The arbiter picks one requester and owns the memory handshake until that requester completes.
- Grants alternate round-robin when both requesters are waiting.
- A bounded timeout returns an error instead of hanging the CPU state machine.

---
 rtl/rv32e_mem_arbiter_pkg.sv | 37 +++
 rtl/rv32e_mem_arbiter_if.sv | 47 ++++
 rtl/rv32e_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_rv32e_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state and grant
// encodings plus the round-robin picker used when both ports compete.
package rv32e_mem_arbiter_pkg;

    // One-hot arbiter states
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'b001,
        ARB_BUSY_IF = 3'b010,
        ARB_BUSY_D  = 3'b100
    } arb_state_e;

    // Identity of the requester that owns the memory
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    // Fetches always read a full word
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Pick the next owner; on a tie the requester not served last wins.
    // Only meaningful when at least one requester is eligible.
    function automatic gnt_e pick_grant(input logic if_elig,
                                        input logic d_elig,
                                        input gnt_e last_grant);
        gnt_e pick;
        if (if_elig && d_elig) begin
            pick = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
        end else if (if_elig) begin
            pick = GNT_IF;
        end else begin
            pick = GNT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rv32e_mem_arbiter_if.sv
// Bus bundle between the CPU's fetch and load/store ports, the arbiter and
// the single-ported memory. The arbiter takes the slave view; the CPU plus
// memory side (or a bench) takes the master view.
interface rv32e_mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack, if_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack, if_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/rv32e_mem_arbiter.sv
// Two-port to one-memory arbiter. One requester owns the memory handshake
// from grant until mem_ack or timeout; ties alternate round-robin. All
// outputs are registered; ack/err/rdata are single-cycle pulses.
module rv32e_mem_arbiter
    import rv32e_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    rv32e_mem_arbiter_if.slave bus
);

    // Counter must hold TIMEOUT_CYCLES-1; keep at least one bit when disabled
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 32'd0) ? 1 : $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam int unsigned CNT_LAST   = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

    arb_state_e         state_q;
    gnt_e               last_grant_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               mem_req_q;
    logic               mem_we_q;
    logic [3:0]         mem_be_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [31:0]        if_rdata_q;
    logic               if_ack_q;
    logic               if_err_q;
    logic [31:0]        d_rdata_q;
    logic               d_ack_q;
    logic               d_err_q;

    logic               if_elig_s;
    logic               d_elig_s;
    logic               grant_vld_s;
    gnt_e               grant_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               timeout_hit_s;

    // Eligibility masks out a requester during its own ack cycle, while it drops req
    always_comb begin
        if_elig_s     = bus.if_req && !if_ack_q;
        d_elig_s      = bus.d_req && !d_ack_q;
        grant_vld_s   = if_elig_s || d_elig_s;
        grant_d       = pick_grant(if_elig_s, d_elig_s, last_grant_q);
        cnt_d         = cnt_q + CNT_W'(1'b1);
        timeout_hit_s = TIMEOUT_EN && (cnt_q == CNT_W'(CNT_LAST));
    end

    // Arbitration FSM: grant, wait for memory or timeout, pulse the owner's ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_D;
            cnt_q        <= {CNT_W{1'b0}};
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            if_rdata_q   <= 32'h0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            d_rdata_q    <= 32'h0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            if_rdata_q <= 32'h0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_vld_s) begin
                        mem_req_q    <= 1'b1;
                        last_grant_q <= grant_d;
                        cnt_q        <= {CNT_W{1'b0}};
                        if (grant_d == GNT_IF) begin
                            state_q     <= ARB_BUSY_IF;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= BE_WORD;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= 32'h0;
                        end else begin
                            state_q     <= ARB_BUSY_D;
                            mem_we_q    <= bus.d_we;
                            mem_be_q    <= bus.d_be;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                        end
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_BUSY_IF: begin
                    if (bus.mem_ack) begin
                        if_rdata_q <= bus.mem_rdata;
                        if_ack_q   <= 1'b1;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        state_q    <= ARB_IDLE;
                    end else if (timeout_hit_s) begin
                        if_ack_q  <= 1'b1;
                        if_err_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ARB_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ARB_BUSY_D: begin
                    if (bus.mem_ack) begin
                        // Stores return no data
                        d_rdata_q <= mem_we_q ? 32'h0 : bus.mem_rdata;
                        d_ack_q   <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ARB_IDLE;
                    end else if (timeout_hit_s) begin
                        d_ack_q   <= 1'b1;
                        d_err_q   <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= ARB_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Directed bench for rv32e_mem_arbiter with an ownership-level reference
// model compared against every output on every cycle.
module tb_rv32e_mem_arbiter;

    localparam int unsigned TO = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    bit   cmp_en;
    bit   log_en;

    rv32e_mem_arbiter_if bus ();

    rv32e_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory responder (stimulus only) ----------------
    int          mem_lat;     // ack in this mem_req cycle; 0 = never
    logic [31:0] mem_resp;
    bit          stale_ack;
    logic [31:0] stale_data;
    int          run_len;

    always @(posedge clk) begin
        #2;
        if (bus.mem_req) run_len = run_len + 1;
        else             run_len = 0;
        if (stale_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = stale_data;
        end else if (bus.mem_req && mem_lat != 0 && run_len == mem_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_resp;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
        end
    end

    // ---------------- reference model ----------------
    // owner: 0 none, 1 fetch, 2 data. cyc counts mem_req-high cycles so far.
    int          owner, last, cyc, pick;
    bit          want_if, want_d, prev_if_ack, prev_d_ack;
    logic        e_mem_req, e_mem_we, e_if_ack, e_if_err, e_d_ack, e_d_err;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

    always @(posedge clk) begin
        if (!reset) begin
            owner = 0; last = 2; cyc = 0;
            e_mem_req = 0; e_mem_we = 0; e_mem_be = 4'h0; e_mem_addr = 32'h0; e_mem_wdata = 32'h0;
            e_if_ack = 0; e_if_err = 0; e_if_rdata = 32'h0;
            e_d_ack = 0; e_d_err = 0; e_d_rdata = 32'h0;
        end else begin
            prev_if_ack = e_if_ack;
            prev_d_ack  = e_d_ack;
            e_if_ack = 0; e_if_err = 0; e_if_rdata = 32'h0;
            e_d_ack = 0; e_d_err = 0; e_d_rdata = 32'h0;
            if (owner == 0) begin
                want_if = bus.if_req && !prev_if_ack;
                want_d  = bus.d_req && !prev_d_ack;
                pick = 0;
                if (want_if && want_d) pick = (last == 1) ? 2 : 1;
                else if (want_if)      pick = 1;
                else if (want_d)       pick = 2;
                if (pick == 1) begin
                    e_mem_we = 0; e_mem_be = 4'hF; e_mem_addr = bus.if_addr; e_mem_wdata = 32'h0;
                end else if (pick == 2) begin
                    e_mem_we = bus.d_we; e_mem_be = bus.d_be; e_mem_addr = bus.d_addr; e_mem_wdata = bus.d_wdata;
                end
                if (pick != 0) begin
                    owner = pick; last = pick; cyc = 1; e_mem_req = 1;
                end
            end else if (bus.mem_ack) begin
                if (owner == 1) begin
                    e_if_ack = 1; e_if_rdata = bus.mem_rdata;
                end else begin
                    e_d_ack = 1; e_d_rdata = e_mem_we ? 32'h0 : bus.mem_rdata;
                end
                owner = 0; e_mem_req = 0; e_mem_we = 0;
            end else if (TO != 0 && cyc == TO) begin
                if (owner == 1) begin e_if_ack = 1; e_if_err = 1; end
                else            begin e_d_ack = 1;  e_d_err = 1;  end
                owner = 0; e_mem_req = 0;
            end else begin
                cyc = cyc + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc.mem_req",   32'(bus.mem_req),   32'(e_mem_req));
            chk("cyc.mem_we",    32'(bus.mem_we),    32'(e_mem_we));
            chk("cyc.mem_be",    32'(bus.mem_be),    32'(e_mem_be));
            chk("cyc.mem_addr",  bus.mem_addr,       e_mem_addr);
            chk("cyc.mem_wdata", bus.mem_wdata,      e_mem_wdata);
            chk("cyc.if_ack",    32'(bus.if_ack),    32'(e_if_ack));
            chk("cyc.if_err",    32'(bus.if_err),    32'(e_if_err));
            chk("cyc.if_rdata",  bus.if_rdata,       e_if_rdata);
            chk("cyc.d_ack",     32'(bus.d_ack),     32'(e_d_ack));
            chk("cyc.d_err",     32'(bus.d_err),     32'(e_d_err));
            chk("cyc.d_rdata",   bus.d_rdata,        e_d_rdata);
        end
    end

    // Grant order log: address seen on each rising mem_req
    logic [31:0] gnt_log[$];
    logic        prev_req;
    always @(negedge clk) begin
        if (log_en && bus.mem_req === 1'b1 && prev_req !== 1'b1) gnt_log.push_back(bus.mem_addr);
        prev_req = bus.mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        chk({p, ".mem_req"},   32'(bus.mem_req),  32'h0);
        chk({p, ".mem_we"},    32'(bus.mem_we),   32'h0);
        chk({p, ".mem_be"},    32'(bus.mem_be),   32'h0);
        chk({p, ".mem_addr"},  bus.mem_addr,      32'h0);
        chk({p, ".mem_wdata"}, bus.mem_wdata,     32'h0);
        chk({p, ".if_ack"},    32'(bus.if_ack),   32'h0);
        chk({p, ".if_err"},    32'(bus.if_err),   32'h0);
        chk({p, ".if_rdata"},  bus.if_rdata,      32'h0);
        chk({p, ".d_ack"},     32'(bus.d_ack),    32'h0);
        chk({p, ".d_err"},     32'(bus.d_err),    32'h0);
        chk({p, ".d_rdata"},   bus.d_rdata,       32'h0);
    endtask

    // Step until the chosen port acks (bounded), counting mem_req-high cycles
    task automatic run_to_ack(input bit is_d, input int max_cyc, output int req_cyc,
                              output bit seen, output logic [31:0] rdata, output logic err);
        req_cyc = 0; seen = 0; rdata = 32'h0; err = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (bus.mem_req) req_cyc++;
            if (is_d ? bus.d_ack : bus.if_ack) begin
                seen  = 1;
                rdata = is_d ? bus.d_rdata : bus.if_rdata;
                err   = is_d ? bus.d_err : bus.if_err;
            end
        end
    endtask

    task automatic drain(input int n);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (n) tick();
    endtask

    // One-cycle mem_ack while the arbiter is idle; nothing may happen
    task automatic stale_pulse(input string p);
        stale_ack = 1; stale_data = 32'h0000_0055;
        tick();
        stale_ack = 0;
        chk({p, ".if_ack"}, 32'(bus.if_ack), 32'h0);
        chk({p, ".d_ack"},  32'(bus.d_ack),  32'h0);
        chk({p, ".mem_req"}, 32'(bus.mem_req), 32'h0);
        tick();
        chk({p, ".if_ack2"}, 32'(bus.if_ack), 32'h0);
        chk({p, ".d_ack2"},  32'(bus.d_ack),  32'h0);
        chk({p, ".mem_req2"}, 32'(bus.mem_req), 32'h0);
    endtask

    int          n;
    bit          seen;
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_gnt [4];

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; cmp_en = 0; log_en = 0;
        reset = 1'b0;
        bus.if_req = 0; bus.if_addr = 32'h0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        mem_lat = 1; mem_resp = 32'h0; stale_ack = 0; stale_data = 32'h0;

        // Reset state
        tick();
        cmp_en = 1;
        tick();
        check_zero("rst");
        reset = 1'b1;

        // 1. Fetch only, memory acks in first cycle
        bus.if_req = 1; bus.if_addr = 32'h40; mem_lat = 1; mem_resp = 32'h0050_0093;
        tick();
        chk("t1.mem_req",  32'(bus.mem_req), 32'h1);
        chk("t1.mem_addr", bus.mem_addr,     32'h40);
        chk("t1.mem_we",   32'(bus.mem_we),  32'h0);
        chk("t1.mem_be",   32'(bus.mem_be),  32'hF);
        tick();
        chk("t1.if_ack",   32'(bus.if_ack),  32'h1);
        chk("t1.if_rdata", bus.if_rdata,     32'h0050_0093);
        chk("t1.if_err",   32'(bus.if_err),  32'h0);
        bus.if_req = 0;
        tick();
        chk("t1.ack_gone", 32'(bus.if_ack),  32'h0);
        chk("t1.rdata_0",  bus.if_rdata,     32'h0);
        chk("t1.no_regnt", 32'(bus.mem_req), 32'h0);
        tick();
        chk("t1.no_regnt2", 32'(bus.mem_req), 32'h0);

        // 2. Simultaneous requests right after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        gnt_log.delete();
        log_en = 1;
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        mem_resp = 32'h1111_1111;
        tick();
        chk("t2.first_if", bus.mem_addr, 32'h200);
        tick();
        chk("t2.if_ack", 32'(bus.if_ack), 32'h1);
        tick();
        chk("t2.d_req",   32'(bus.mem_req), 32'h1);
        chk("t2.d_addr",  bus.mem_addr,     32'h100);
        chk("t2.d_we",    32'(bus.mem_we),  32'h1);
        chk("t2.d_be",    32'(bus.mem_be),  32'h3);
        chk("t2.d_wdata", bus.mem_wdata,    32'hDEAD_BEEF);
        tick();
        chk("t2.d_ack",       32'(bus.d_ack), 32'h1);
        chk("t2.store_rdata", bus.d_rdata,    32'h0);
        for (int i = 0; i < 40 && gnt_log.size() < 4; i++) tick();
        exp_gnt[0] = 32'h200; exp_gnt[1] = 32'h100; exp_gnt[2] = 32'h200; exp_gnt[3] = 32'h100;
        chk("t2.gnt_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2.gnt_order", gnt_log[i], exp_gnt[i]);
        log_en = 0;
        drain(6);

        // 3. Load with 3-cycle memory latency
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h300; bus.d_wdata = 32'h0;
        mem_lat = 3; mem_resp = 32'h1234_5678;
        run_to_ack(1'b1, 20, n, seen, rd, er);
        chk("t3.seen",     32'(seen), 32'h1);
        chk("t3.req_cyc",  32'(n),    32'd3);
        chk("t3.d_rdata",  rd,        32'h1234_5678);
        chk("t3.d_err",    32'(er),   32'h0);
        bus.d_req = 0;
        tick();
        chk("t3.rdata_0",  bus.d_rdata,    32'h0);

        // 4. Timeout, then a normal data request
        bus.if_req = 1; bus.if_addr = 32'h400; mem_lat = 0;
        run_to_ack(1'b0, 20, n, seen, rd, er);
        chk("t4.seen",     32'(seen), 32'h1);
        chk("t4.req_cyc",  32'(n),    32'd4);
        chk("t4.if_err",   32'(er),   32'h1);
        chk("t4.if_rdata", rd,        32'h0);
        bus.if_req = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500; mem_lat = 1; mem_resp = 32'hCAFE_F00D;
        run_to_ack(1'b1, 20, n, seen, rd, er);
        chk("t4.d_seen",   32'(seen), 32'h1);
        chk("t4.d_cyc",    32'(n),    32'd1);
        chk("t4.d_rdata",  rd,        32'hCAFE_F00D);
        chk("t4.d_err",    32'(er),   32'h0);
        drain(2);

        // 5. Reset while data transaction is in flight
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h600; mem_lat = 0;
        tick();
        tick();
        chk("t5.busy_req",  32'(bus.mem_req), 32'h1);
        chk("t5.busy_addr", bus.mem_addr,     32'h600);
        reset = 1'b0;
        tick();
        check_zero("t5.rst");
        reset = 1'b1;
        bus.d_req = 0;
        tick();
        chk("t5.post_req", 32'(bus.mem_req), 32'h0);
        chk("t5.post_ack", 32'(bus.d_ack),   32'h0);
        stale_pulse("t5.stale");

        // 6a. Stale ack in idle without a preceding reset
        stale_pulse("t6.stale");

        // 6b. if_req held through the ack cycle, then dropped: no regrant
        bus.if_req = 1; bus.if_addr = 32'h700; mem_lat = 1; mem_resp = 32'h0BAD_C0DE;
        tick();
        tick();
        chk("t6.ack",       32'(bus.if_ack),  32'h1);
        chk("t6.rdata",     bus.if_rdata,     32'h0BAD_C0DE);
        tick();
        chk("t6.no_regnt",  32'(bus.mem_req), 32'h0);
        bus.if_req = 0;
        tick();
        chk("t6.no_regnt2", 32'(bus.mem_req), 32'h0);

        // 6c. if_req still high the cycle after ack: regranted
        bus.if_req = 1;
        tick();
        tick();
        chk("t6c.ack",      32'(bus.if_ack),  32'h1);
        tick();
        chk("t6c.gap",      32'(bus.mem_req), 32'h0);
        tick();
        chk("t6c.regnt",    32'(bus.mem_req), 32'h1);
        chk("t6c.addr",     bus.mem_addr,     32'h700);
        drain(4);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
